axis_rr_arbiter: RTL and testbench
==================================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters and SHALL be in the range 2..8.
REQ-002 Parameter DATA_W, default 32, is the data width in bits.
REQ-003 Port ACLK, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port ARST, input, 1 bit: synchronous, active-high reset.
REQ-005 Port S_TVALID, input, N_REQ bits: per-requester valid.
REQ-006 Port S_TDATA, input, N_REQ*DATA_W bits: per-requester data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port S_TLAST, input, N_REQ bits: per-requester end-of-packet flag.
REQ-008 Port S_TREADY, output, N_REQ bits: per-requester ready.
REQ-009 Port M_TVALID, output, 1 bit: downstream valid (registered).
REQ-010 Port M_TDATA, output, DATA_W bits: downstream data (registered).
REQ-011 Port M_TLAST, output, 1 bit: downstream last (registered).
REQ-012 Port M_TREADY, input, 1 bit: downstream ready.
REQ-013 Port GRANT_ID, output, clog2(N_REQ) bits: index of the current or most recent grant (registered).
REQ-014 Port BUSY, output, 1 bit: high while the FSM is in XFER.

Function
REQ-015 The FSM SHALL have two states, IDLE and XFER.
REQ-016 In IDLE with any S_TVALID bit high, the block SHALL grant the first valid requester in round-robin order starting at GRANT_ID+1 (mod N_REQ), load that index into GRANT_ID, and move to XFER on the next edge.
REQ-017 In IDLE with no S_TVALID bit high, the FSM SHALL stay in IDLE and GRANT_ID SHALL hold its value.
REQ-018 S_TREADY[i] SHALL be combinational and equal (state==XFER) && (i==GRANT_ID) && (!M_TVALID || M_TREADY); every other S_TREADY bit SHALL be 0.
REQ-019 A beat is accepted when S_TVALID[g] && S_TREADY[g]; on that edge M_TDATA, M_TLAST and M_TVALID SHALL load S_TDATA[g], S_TLAST[g] and 1.
REQ-020 On a downstream handshake (M_TVALID && M_TREADY) with no beat accepted in the same cycle, M_TVALID SHALL clear to 0.
REQ-021 When a beat is accepted in the same cycle as a downstream handshake, M_TVALID SHALL stay 1 and the output register SHALL carry the new beat; throughput SHALL be one beat per cycle inside a locked packet.
REQ-022 While M_TVALID=1 and M_TREADY=0, M_TDATA and M_TLAST SHALL be held stable and no beat SHALL be accepted.
REQ-023 Latency from a beat being accepted to that beat appearing on M_TVALID/M_TDATA SHALL be exactly 1 cycle.
REQ-024 In XFER, if the granted requester has S_TVALID=0, the FSM SHALL wait in XFER; the grant SHALL NOT move to another requester.
REQ-025 The round-robin order SHALL wrap from index N_REQ-1 to index 0.
REQ-026 A requester with its S_TVALID bit low SHALL never be granted.

Reset
REQ-027 While ARST=1 at a rising edge: state SHALL be IDLE, M_TVALID=0, M_TDATA=0, M_TLAST=0, GRANT_ID=N_REQ-1 (so that requester 0 wins first), BUSY=0, and all S_TREADY bits SHALL be 0.
REQ-028 Reset asserted mid-packet SHALL discard the output register and the grant with no further beats emitted; the first arbitration after reset SHALL follow REQ-016.

Configuration
REQ-029 With macro AXIS_ARB_PKT_LOCK_EN defined, the grant SHALL be held through a packet: XFER returns to IDLE only on the edge that accepts a beat with S_TLAST[g]=1.
REQ-030 With AXIS_ARB_PKT_LOCK_EN undefined, S_TLAST SHALL be passed through to M_TLAST but ignored for arbitration, and XFER SHALL return to IDLE after every accepted beat (per-beat round robin, at most one beat every 2 cycles).

Verification
REQ-031 Reset then S_TVALID=4'b1111 with M_TREADY=1 and no lock: the grant sequence SHALL be 0,1,2,3,0, with M_TDATA following each requester's data.
REQ-032 Lock enabled, requester 2 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with TLAST on the third beat) while requester 0 is also valid: requester 0 SHALL be granted only after 0xA3 is accepted, and the three beats SHALL appear on consecutive cycles.
REQ-033 M_TREADY=0 for 5 cycles with M_TVALID=1 and M_TDATA=0xDEADBEEF: M_TDATA SHALL stay stable, S_TREADY SHALL be 0, and there SHALL be no data loss when M_TREADY returns to 1.
REQ-034 Only requester 3 is valid, with GRANT_ID=3: requester 3 SHALL be granted again via wrap-around.
REQ-035 ARST pulsed for 1 cycle on the second beat of a locked packet: M_TVALID SHALL be 0 on the next cycle and the next grant SHALL go to requester 0 if it is valid.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin N_REQ-to-1 AXI-Stream arbiter with a registered output stage.
// Define AXIS_ARB_PKT_LOCK_EN to hold the grant until TLAST; otherwise the grant is released after every beat.
module axis_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic                      ACLK,
    input  logic                      ARST,
    input  logic [N_REQ-1:0]          S_TVALID,
    input  logic [N_REQ*DATA_W-1:0]   S_TDATA,
    input  logic [N_REQ-1:0]          S_TLAST,
    output logic [N_REQ-1:0]          S_TREADY,
    output logic                      M_TVALID,
    output logic [DATA_W-1:0]         M_TDATA,
    output logic                      M_TLAST,
    input  logic                      M_TREADY,
    output logic [$clog2(N_REQ)-1:0]  GRANT_ID,
    output logic                      BUSY
);
    localparam int GW = $clog2(N_REQ);
    localparam int SW = GW + 1;
    typedef enum logic {IDLE, XFER} state_t;
    state_t state, state_nxt;
    logic [GW-1:0] pick;
    logic [SW-1:0] sum;
    logic found, out_ready, accept, release_grant;
    assign out_ready = !M_TVALID || M_TREADY;
    assign BUSY = (state == XFER);
    always_comb begin
        S_TREADY = '0;
        if (state == XFER && out_ready) S_TREADY[GRANT_ID] = 1'b1;
    end
    assign accept = S_TVALID[GRANT_ID] && S_TREADY[GRANT_ID];
`ifdef AXIS_ARB_PKT_LOCK_EN
    assign release_grant = accept && S_TLAST[GRANT_ID];
`else
    assign release_grant = accept;
`endif
    // Scan GRANT_ID+1 .. GRANT_ID+N_REQ (mod N_REQ); the last candidate is the previous winner itself.
    always_comb begin
        pick = GRANT_ID;
        found = 1'b0;
        sum = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, GRANT_ID} + SW'(k);
            if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
            if (!found && S_TVALID[sum[GW-1:0]]) begin
                pick = sum[GW-1:0];
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (found ? XFER : IDLE) : (release_grant ? IDLE : XFER);
    end
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state    <= IDLE;
            GRANT_ID <= GW'(N_REQ - 1);
            M_TVALID <= 1'b0;
            M_TDATA  <= '0;
            M_TLAST  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) GRANT_ID <= pick;
            if (accept) begin
                M_TVALID <= 1'b1;
                M_TDATA  <= S_TDATA[GRANT_ID*DATA_W +: DATA_W];
                M_TLAST  <= S_TLAST[GRANT_ID];
            end else if (M_TREADY) begin
                M_TVALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed stimulus with a queue scoreboard checked by a separate output monitor.
module tb_axis_rr_arbiter;
    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic [3:0]  S_TVALID = '0;
    logic [31:0] d [4];
    logic [3:0]  S_TLAST = '0;
    logic [3:0]  S_TREADY;
    logic        M_TVALID;
    logic [31:0] M_TDATA;
    logic        M_TLAST;
    logic        M_TREADY = 1'b1;
    logic [1:0]  GRANT_ID;
    logic        BUSY;
    logic [127:0] S_TDATA;
    typedef struct {logic [31:0] data; logic last; logic [1:0] gid;} beat_t;
    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int n;

    assign S_TDATA = {d[3], d[2], d[1], d[0]};
    always #5 ACLK = ~ACLK;

    axis_rr_arbiter #(.N_REQ(4), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARST(ARST), .S_TVALID(S_TVALID), .S_TDATA(S_TDATA),
        .S_TLAST(S_TLAST), .S_TREADY(S_TREADY), .M_TVALID(M_TVALID),
        .M_TDATA(M_TDATA), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY),
        .GRANT_ID(GRANT_ID), .BUSY(BUSY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic last, input logic [1:0] gid);
        beat_t b;
        b.data = data;
        b.last = last;
        b.gid  = gid;
        exp_q.push_back(b);
    endtask

    // Returns #1 after the edge that accepts a beat from requester i; cnt = idle cycles waited.
    task automatic wait_accept(input int i, output int cnt);
        cnt = 0;
        forever begin
            @(negedge ACLK);
            if (S_TVALID[i] && S_TREADY[i]) break;
            cnt++;
            if (cnt > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout req %0d: no handshake within 50 cycles", i);
                break;
            end
        end
        @(posedge ACLK);
        #1;
    endtask

    always @(negedge ACLK) begin
        if (!ARST && M_TVALID && M_TREADY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data %h grant %0d, expected none", M_TDATA, GRANT_ID);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                if (M_TDATA !== b.data || M_TLAST !== b.last || GRANT_ID !== b.gid) begin
                    errors++;
                    $display("FAIL out_beat: got data %h last %b grant %0d, expected data %h last %b grant %0d",
                             M_TDATA, M_TLAST, GRANT_ID, b.data, b.last, b.gid);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) d[i] = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_m_tvalid", {31'b0, M_TVALID}, 0);
        chk("rst_m_tdata", M_TDATA, 0);
        chk("rst_m_tlast", {31'b0, M_TLAST}, 0);
        chk("rst_grant_id", {30'b0, GRANT_ID}, 3);
        chk("rst_busy", {31'b0, BUSY}, 0);
        chk("rst_s_tready", {28'b0, S_TREADY}, 0);
        @(posedge ACLK);
        #1 ARST = 1'b0;

        // all four valid: grants 0,1,2,3,0
        for (int i = 0; i < 4; i++) d[i] = 32'h100 + i;
        S_TLAST = 4'b1111;
        S_TVALID = 4'b1111;
        for (int k = 0; k < 5; k++) push(32'h100 + (k % 4), 1'b1, 2'(k % 4));
        for (int k = 0; k < 5; k++) wait_accept(k % 4, n);
        S_TVALID = '0;
        repeat (2) @(posedge ACLK);
        #1;

        // downstream stall holds DEADBEEF, then both beats drain in order
        M_TREADY = 1'b0;
        d[1] = 32'hDEADBEEF;
        S_TVALID = 4'b0010;
        push(32'hDEADBEEF, 1'b1, 2'd1);
        push(32'hCAFEF00D, 1'b1, 2'd1);
        wait_accept(1, n);
        d[1] = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("stall_m_tvalid", {31'b0, M_TVALID}, 1);
            chk("stall_m_tdata", M_TDATA, 32'hDEADBEEF);
            chk("stall_s_tready", {28'b0, S_TREADY}, 0);
        end
        @(posedge ACLK);
        #1 M_TREADY = 1'b1;
        wait_accept(1, n);
        S_TVALID = '0;
        repeat (2) @(posedge ACLK);
        #1;

        // only requester 3: reached from 1, then re-granted via wrap
        d[3] = 32'h33330001;
        S_TVALID = 4'b1000;
        push(32'h33330001, 1'b1, 2'd3);
        push(32'h33330002, 1'b1, 2'd3);
        wait_accept(3, n);
        chk("wrap_grant_before", {30'b0, GRANT_ID}, 3);
        d[3] = 32'h33330002;
        wait_accept(3, n);
        S_TVALID = '0;
        repeat (2) @(posedge ACLK);
        #1;

        // grant stays on requester 0 while it drops valid, even with requester 2 waiting
        d[0] = 32'h0A0A0A0A;
        S_TLAST = 4'b0001;
        S_TVALID = 4'b0001;
        @(posedge ACLK);
        #1 S_TVALID = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            chk("hold_busy", {31'b0, BUSY}, 1);
            chk("hold_grant", {30'b0, GRANT_ID}, 0);
            chk("hold_s_tready", {28'b0, S_TREADY}, 4'b0001);
        end
        @(posedge ACLK);
        #1 S_TVALID = 4'b0101;
        push(32'h0A0A0A0A, 1'b1, 2'd0);
        wait_accept(0, n);
        S_TVALID = '0;
        repeat (2) @(posedge ACLK);
        #1;

`ifdef AXIS_ARB_PKT_LOCK_EN
        // locked 3-beat packet from requester 2 while requester 0 waits
        d[2] = 32'hA1;
        S_TLAST = 4'b0001;
        d[0] = 32'hB0;
        S_TVALID = 4'b0101;
        push(32'hA1, 1'b0, 2'd2);
        push(32'hA2, 1'b0, 2'd2);
        push(32'hA3, 1'b1, 2'd2);
        push(32'hB0, 1'b1, 2'd0);
        wait_accept(2, n);
        d[2] = 32'hA2;
        wait_accept(2, n);
        chk("lock_beat2_gap", n, 0);
        d[2] = 32'hA3;
        S_TLAST = 4'b0101;
        wait_accept(2, n);
        chk("lock_beat3_gap", n, 0);
        S_TVALID = 4'b0001;
        wait_accept(0, n);
        S_TVALID = '0;
`else
        // per-beat round robin alternates 2,0,2,0 with TLAST passed through
        d[2] = 32'h2222;
        d[0] = 32'h0000_1111;
        S_TLAST = 4'b0100;
        S_TVALID = 4'b0101;
        for (int k = 0; k < 4; k++) push(k[0] ? 32'h1111 : 32'h2222, !k[0], k[0] ? 2'd0 : 2'd2);
        for (int k = 0; k < 4; k++) begin
            wait_accept(k[0] ? 0 : 2, n);
            if (k > 0) chk("rr_beat_gap", n, 1);
        end
        S_TVALID = '0;
`endif
        repeat (2) @(posedge ACLK);
        #1;

        // reset mid-packet discards the stalled beat; next grant goes to requester 0
        M_TREADY = 1'b0;
        d[1] = 32'hC1;
        S_TLAST = 4'b0001;
        S_TVALID = 4'b0010;
        wait_accept(1, n);
        ARST = 1'b1;
        d[1] = 32'hC2;
        d[0] = 32'hD0;
        S_TVALID = 4'b0011;
        @(posedge ACLK);
        #1 ARST = 1'b0;
        M_TREADY = 1'b1;
        @(negedge ACLK);
        chk("post_rst_m_tvalid", {31'b0, M_TVALID}, 0);
        chk("post_rst_grant", {30'b0, GRANT_ID}, 3);
        chk("post_rst_busy", {31'b0, BUSY}, 0);
        push(32'hD0, 1'b1, 2'd0);
        wait_accept(0, n);
        S_TVALID = '0;
        repeat (5) @(negedge ACLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
